iob_fifo_sync_asym: RTL and testbench
=====================================

IOB_FIFO_SYNC_ASYM -- requirements
Module: iob_fifo_sync_asym

Interface
REQ-001 SHALL have parameter W_DATA_W, default 8: write word width in bits.
REQ-002 SHALL have parameter R_DATA_W, default 32: read word width in bits.
REQ-003 SHALL have parameter ADDR_W, default 4: log2 of FIFO depth, counted in MINDATA_W units.
REQ-004 SHALL have parameter BIG_ENDIAN, default 0: 1 places the first narrow word in the most-significant slice of a wide word.
REQ-005 SHALL derive localparams MAXDATA_W, MINDATA_W, R = MAXDATA_W/MINDATA_W, W_INCR and R_INCR; these are not overridable.
REQ-006 SHALL define the clock and reset as: clk_i input 1, clock; arst_n_i input 1, asynchronous active-low reset.
REQ-007 SHALL have these ports: cke_i input 1, clock enable; flush_i input 1, synchronous clear.
REQ-008 SHALL have these write ports: w_en_i input 1, write request; w_data_i input W_DATA_W, write data; w_full_o output 1, no room for a write word.
REQ-009 SHALL have these read ports: r_en_i input 1, read request; r_data_o output R_DATA_W, read data; r_empty_o output 1, less than one read word stored.
REQ-010 SHALL have these level ports: level_o output ADDR_W+1, occupancy in MINDATA_W units; almost_full_lvl_i input ADDR_W+1, threshold; almost_empty_lvl_i input ADDR_W+1, threshold; almost_full_o output 1; almost_empty_o output 1.
REQ-011 SHALL have these error ports: overflow_o output 1, sticky write-while-full; underflow_o output 1, sticky read-while-empty.

Function
REQ-012 SHALL hold storage internally as 2^ADDR_W entries of MINDATA_W bits; there is no external memory port.
REQ-013 SHALL set W_INCR = R when W_DATA_W > R_DATA_W, else 1.
REQ-014 SHALL set R_INCR = R when R_DATA_W > W_DATA_W, else 1.
REQ-015 SHALL accept a write iff w_en_i & cke_i & ~w_full_o; the word is stored at wptr and wptr advances by W_INCR.
REQ-016 SHALL accept a read iff r_en_i & cke_i & ~r_empty_o; r_data_o is registered and valid the cycle after acceptance, and holds its value otherwise.
REQ-017 SHALL make w_full_o = (level_o > 2^ADDR_W - W_INCR) and r_empty_o = (level_o < R_INCR), both combinational from registered level.
REQ-018 SHALL accept a simultaneous write and read when each is individually allowed, with level += W_INCR - R_INCR; full/empty are not bypassed by the same-cycle opposite operation.
REQ-019 SHALL keep pointers ADDR_W+1 bits wide and wrap modulo 2^(ADDR_W+1); level = wptr - rptr.
REQ-020 SHALL make almost_full_o = (level_o >= almost_full_lvl_i) and almost_empty_o = (level_o <= almost_empty_lvl_i), both combinational.
REQ-021 SHALL set overflow_o on a rejected write (w_en_i & cke_i & w_full_o) and underflow_o on a rejected read; each stays set until flush or reset.
REQ-022 SHALL, on flush_i & cke_i, clear the pointers, level and sticky flags next cycle; flush takes priority over any same-cycle read or write, and r_data_o is retained.
REQ-023 SHALL pack and unpack narrow words by BIG_ENDIAN: index i of R occupies bits [i*MINDATA_W +: MINDATA_W], or the mirrored slice when BIG_ENDIAN=1.
REQ-024 SHALL freeze all state while cke_i=0.

Reset
REQ-025 SHALL, while arst_n_i=0, asynchronously set pointers=0, level_o=0, r_data_o=0, overflow_o=0, underflow_o=0.
REQ-026 SHALL, as a result, hold w_full_o=0 and r_empty_o=1 during reset; storage contents are not reset.
REQ-027 SHALL take effect when reset asserts mid-operation, discarding any in-flight accepted transfer.

Structure
REQ-028 SHALL place the iob_max/iob_min functions and the R/INCR derivation in the shared iob_fifo package/include.
REQ-029 SHALL use one sub-module, iob_fifo_ctrl (pointers, level, flags); storage and packing stay in the top.

Verification
REQ-030 SHALL cover: defaults; write 0x11,0x22,0x33,0x44 then r_en -> r_data_o=0x44332211 one cycle later, r_empty_o=1.
REQ-031 SHALL cover: BIG_ENDIAN=1, same stimulus -> r_data_o=0x11223344.
REQ-032 SHALL cover: 16 writes -> w_full_o=1, level_o=16; a 17th write -> overflow_o=1, level_o unchanged; flush -> level_o=0, overflow_o=0.
REQ-033 SHALL cover: read when empty -> underflow_o=1, r_data_o unchanged.
REQ-034 SHALL cover: thresholds 12/4; level 12 -> almost_full_o=1; level 4 -> almost_empty_o=1.
REQ-035 SHALL cover: W=R=8, level 16, simultaneous r_en and w_en -> read accepted, write rejected, level_o=15.

Source files
------------

// File: rtl/iob_fifo_pkg.sv
// Shared helpers for the asymmetric FIFO: width min/max, ratio and pointer increments.
package iob_fifo_pkg;

  function automatic int unsigned iob_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned iob_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Pointer step for one side: the wide side moves R narrow entries per word.
  function automatic int unsigned iob_incr(input int unsigned this_w, input int unsigned other_w,
                                           input int unsigned ratio);
    return (this_w > other_w) ? ratio : 1;
  endfunction

  // Slice index of narrow word idx within an n-slice wide word (mirrored when big-endian).
  function automatic int unsigned iob_slice(input int unsigned idx, input int unsigned n,
                                            input logic big);
    return big ? (n - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/iob_fifo_ctrl.sv
// Pointer, level and status-flag control for the synchronous asymmetric FIFO.
module iob_fifo_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned W_INCR = 1,
  parameter int unsigned R_INCR = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              flush_i,
  input  logic              w_en_i,
  input  logic              r_en_i,
  input  logic [ADDR_W:0]   almost_full_lvl_i,
  input  logic [ADDR_W:0]   almost_empty_lvl_i,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [ADDR_W-1:0] r_addr_o,
  output logic              w_accept_c_o,
  output logic              r_accept_c_o,
  output logic [ADDR_W:0]   level_o,
  output logic              w_full_o,
  output logic              r_empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned   DEPTH    = 2 ** ADDR_W;
  localparam int unsigned   PTR_W    = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_LVL = PTR_W'(DEPTH - W_INCR);
  localparam logic [ADDR_W:0] W_STEP   = PTR_W'(W_INCR);
  localparam logic [ADDR_W:0] R_STEP   = PTR_W'(R_INCR);

  logic [ADDR_W:0] w_ptr_q, w_ptr_d;
  logic [ADDR_W:0] r_ptr_q, r_ptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            full_c, empty_c, w_acc_c, r_acc_c;

  // Flags from registered level, transfer acceptance and next-state computation.
  always_comb begin
    full_c  = level_q > FULL_LVL;
    empty_c = level_q < R_STEP;
    w_acc_c = w_en_i & cke_i & ~full_c & ~flush_i;
    r_acc_c = r_en_i & cke_i & ~empty_c & ~flush_i;
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (cke_i) begin
      if (flush_i) begin
        w_ptr_d = '0;
        r_ptr_d = '0;
        level_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end else begin
        if (w_acc_c) w_ptr_d = w_ptr_q + W_STEP;
        if (r_acc_c) r_ptr_d = r_ptr_q + R_STEP;
        level_d = w_ptr_d - r_ptr_d;
        ovf_d   = ovf_q | (w_en_i & full_c);
        unf_d   = unf_q | (r_en_i & empty_c);
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign w_addr_o       = w_ptr_q[ADDR_W-1:0];
  assign r_addr_o       = r_ptr_q[ADDR_W-1:0];
  assign w_accept_c_o   = w_acc_c;
  assign r_accept_c_o   = r_acc_c;
  assign level_o        = level_q;
  assign w_full_o       = full_c;
  assign r_empty_o      = empty_c;
  assign almost_full_o  = level_q >= almost_full_lvl_i;
  assign almost_empty_o = level_q <= almost_empty_lvl_i;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: rtl/iob_fifo_sync_asym.sv
// Synchronous FIFO with independent write/read word widths; narrow-unit storage and packing.
module iob_fifo_sync_asym
  import iob_fifo_pkg::*;
#(
  parameter int unsigned W_DATA_W   = 8,
  parameter int unsigned R_DATA_W   = 32,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                flush_i,
  input  logic                w_en_i,
  input  logic [W_DATA_W-1:0] w_data_i,
  output logic                w_full_o,
  input  logic                r_en_i,
  output logic [R_DATA_W-1:0] r_data_o,
  output logic                r_empty_o,
  output logic [ADDR_W:0]     level_o,
  input  logic [ADDR_W:0]     almost_full_lvl_i,
  input  logic [ADDR_W:0]     almost_empty_lvl_i,
  output logic                almost_full_o,
  output logic                almost_empty_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam int unsigned MAXDATA_W = iob_max(W_DATA_W, R_DATA_W);
  localparam int unsigned MINDATA_W = iob_min(W_DATA_W, R_DATA_W);
  localparam int unsigned R         = MAXDATA_W / MINDATA_W;
  localparam int unsigned W_INCR    = iob_incr(W_DATA_W, R_DATA_W, R);
  localparam int unsigned R_INCR    = iob_incr(R_DATA_W, W_DATA_W, R);
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam logic        BIG       = (BIG_ENDIAN != 0);

  logic [ADDR_W-1:0]    w_addr, r_addr;
  logic                 w_accept_c, r_accept_c;
  logic [MINDATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]    w_addr_c [W_INCR];
  logic [MINDATA_W-1:0] w_word_c [W_INCR];
  logic [R_DATA_W-1:0]  r_word_c;
  logic [R_DATA_W-1:0]  r_data_q, r_data_d;

  iob_fifo_ctrl #(
    .ADDR_W (ADDR_W),
    .W_INCR (W_INCR),
    .R_INCR (R_INCR)
  ) u_ctrl (
    .clk_i              (clk_i),
    .arst_n_i           (arst_n_i),
    .cke_i              (cke_i),
    .flush_i            (flush_i),
    .w_en_i             (w_en_i),
    .r_en_i             (r_en_i),
    .almost_full_lvl_i  (almost_full_lvl_i),
    .almost_empty_lvl_i (almost_empty_lvl_i),
    .w_addr_o           (w_addr),
    .r_addr_o           (r_addr),
    .w_accept_c_o       (w_accept_c),
    .r_accept_c_o       (r_accept_c),
    .level_o            (level_o),
    .w_full_o           (w_full_o),
    .r_empty_o          (r_empty_o),
    .almost_full_o      (almost_full_o),
    .almost_empty_o     (almost_empty_o),
    .overflow_o         (overflow_o),
    .underflow_o        (underflow_o)
  );

  // Split the write word into narrow entries and their storage addresses.
  always_comb begin
    for (int unsigned i = 0; i < W_INCR; i++) begin
      w_addr_c[i] = w_addr + ADDR_W'(i);
      w_word_c[i] = w_data_i[iob_slice(i, W_INCR, BIG) * MINDATA_W +: MINDATA_W];
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_accept_c) begin
      for (int unsigned i = 0; i < W_INCR; i++) begin
        mem_q[w_addr_c[i]] <= w_word_c[i];
      end
    end
  end

  // Gather narrow entries into one read word.
  always_comb begin
    r_word_c = '0;
    for (int unsigned i = 0; i < R_INCR; i++) begin
      r_word_c[iob_slice(i, R_INCR, BIG) * MINDATA_W +: MINDATA_W] = mem_q[r_addr + ADDR_W'(i)];
    end
  end

  // Read data only updates on an accepted read.
  always_comb begin
    r_data_d = r_data_q;
    if (r_accept_c) r_data_d = r_word_c;
  end

  // Registered read data with async clear.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_data_q <= '0;
    else           r_data_q <= r_data_d;
  end

  assign r_data_o = r_data_q;

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: 8->32 little- and big-endian instances plus an 8->8 instance.
module tb_iob_fifo_sync_asym;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cke, flush, w_en, r_en;
  logic [7:0]  w_data;
  logic [4:0]  afl, ael;

  logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [31:0] a_rdata;
  logic [4:0]  a_lvl;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [31:0] b_rdata;
  logic [4:0]  b_lvl;

  logic        n_cke, n_flush, n_w_en, n_r_en;
  logic [7:0]  n_w_data, n_rdata;
  logic        n_full, n_empty, n_af, n_ae, n_ovf, n_unf;
  logic [4:0]  n_lvl;

  iob_fifo_sync_asym dut_a (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .flush_i(flush),
    .w_en_i(w_en), .w_data_i(w_data), .w_full_o(a_full),
    .r_en_i(r_en), .r_data_o(a_rdata), .r_empty_o(a_empty),
    .level_o(a_lvl), .almost_full_lvl_i(afl), .almost_empty_lvl_i(ael),
    .almost_full_o(a_af), .almost_empty_o(a_ae),
    .overflow_o(a_ovf), .underflow_o(a_unf)
  );

  iob_fifo_sync_asym #(.BIG_ENDIAN(1)) dut_b (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .flush_i(flush),
    .w_en_i(w_en), .w_data_i(w_data), .w_full_o(b_full),
    .r_en_i(r_en), .r_data_o(b_rdata), .r_empty_o(b_empty),
    .level_o(b_lvl), .almost_full_lvl_i(afl), .almost_empty_lvl_i(ael),
    .almost_full_o(b_af), .almost_empty_o(b_ae),
    .overflow_o(b_ovf), .underflow_o(b_unf)
  );

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(8)) dut_n (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(n_cke), .flush_i(n_flush),
    .w_en_i(n_w_en), .w_data_i(n_w_data), .w_full_o(n_full),
    .r_en_i(n_r_en), .r_data_o(n_rdata), .r_empty_o(n_empty),
    .level_o(n_lvl), .almost_full_lvl_i(afl), .almost_empty_lvl_i(ael),
    .almost_full_o(n_af), .almost_empty_o(n_ae),
    .overflow_o(n_ovf), .underflow_o(n_unf)
  );

  typedef struct {
    logic       w_en;
    logic [7:0] w_data;
    logic       r_en;
    logic       flush;
    logic       cke;
    logic [4:0] lvl;
    logic       full, empty, af, ae, ovf, unf;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  model_q[$];
  logic [31:0] exp_le_q[$], exp_be_q[$];
  logic [31:0] last_le, last_be;
  int          n_checks, n_pass;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic re,
                              input logic fl, input logic ck, input int lvl,
                              input logic fu, input logic em, input logic af,
                              input logic ae, input logic ov, input logic un);
    vec_t v;
    v.w_en = we; v.w_data = wd; v.r_en = re; v.flush = fl; v.cke = ck;
    v.lvl = 5'(lvl); v.full = fu; v.empty = em; v.af = af; v.ae = ae; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  function automatic logic [10:0] st(input logic [4:0] l, input logic fu, input logic em,
                                     input logic af, input logic ae, input logic ov,
                                     input logic un);
    return {l, fu, em, af, ae, ov, un};
  endfunction

  // Drive one vector, update the byte-level scoreboard, then compare one cycle later.
  task automatic apply(input int idx, input vec_t v);
    logic       rd, wr;
    logic [7:0] b0, b1, b2, b3;
    w_en = v.w_en; w_data = v.w_data; r_en = v.r_en; flush = v.flush; cke = v.cke;
    if (v.cke) begin
      if (v.flush) model_q.delete();
      else begin
        rd = v.r_en && (model_q.size() >= 4);
        wr = v.w_en && (model_q.size() < 16);
        if (rd) begin
          b0 = model_q.pop_front(); b1 = model_q.pop_front();
          b2 = model_q.pop_front(); b3 = model_q.pop_front();
          exp_le_q.push_back({b3, b2, b1, b0});
          exp_be_q.push_back({b0, b1, b2, b3});
        end
        if (wr) model_q.push_back(v.w_data);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check($sformatf("vec%0d status_le", idx),
          64'(st(a_lvl, a_full, a_empty, a_af, a_ae, a_ovf, a_unf)),
          64'(st(v.lvl, v.full, v.empty, v.af, v.ae, v.ovf, v.unf)));
    check($sformatf("vec%0d status_be", idx),
          64'(st(b_lvl, b_full, b_empty, b_af, b_ae, b_ovf, b_unf)),
          64'(st(v.lvl, v.full, v.empty, v.af, v.ae, v.ovf, v.unf)));
    if (exp_le_q.size() > 0) begin
      last_le = exp_le_q.pop_front();
      last_be = exp_be_q.pop_front();
    end
    check($sformatf("vec%0d r_data_le", idx), 64'(a_rdata), 64'(last_le));
    check($sformatf("vec%0d r_data_be", idx), 64'(b_rdata), 64'(last_be));
  endtask

  initial begin
    n_checks = 0; n_pass = 0; last_le = '0; last_be = '0;
    rst_n = 1'b0; cke = 1'b1; flush = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = '0;
    n_cke = 1'b1; n_flush = 1'b0; n_w_en = 1'b0; n_r_en = 1'b0; n_w_data = '0;
    afl = 5'd12; ael = 5'd4;

    // Vector table: w_en, w_data, r_en, flush, cke -> level, full, empty, af, ae, ovf, unf.
    vecs.push_back(mk(1, 8'h11, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 8'h22, 0, 0, 1, 2, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 8'h33, 0, 0, 1, 3, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 8'h44, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 8'h55, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0));
    for (int i = 1; i <= 16; i++) begin
      vecs.push_back(mk(1, 8'(i), 0, 0, 1, i, i == 16, i < 4, i >= 12, i <= 4, 0, 0));
    end
    vecs.push_back(mk(1, 8'h99, 0, 0, 1, 16, 1, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 12, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(1, 8'hAA, 1, 0, 1, 9, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 8'hBB, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 8'hC1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0));

    // Reset state observed while reset is held.
    repeat (2) @(negedge clk);
    check("reset status_le", 64'(st(a_lvl, a_full, a_empty, a_af, a_ae, a_ovf, a_unf)),
          64'(st(5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
    check("reset status_be", 64'(st(b_lvl, b_full, b_empty, b_af, b_ae, b_ovf, b_unf)),
          64'(st(5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
    check("reset r_data", 64'(a_rdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset asserted mid-cycle with a write pending: state clears immediately.
    w_en = 1'b1; w_data = 8'hD2; r_en = 1'b0; flush = 1'b0; cke = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst level", 64'(a_lvl), 64'd0);
    check("midrst full_empty", 64'({a_full, a_empty}), 64'(2'b01));
    check("midrst r_data", 64'(a_rdata), 64'd0);
    @(negedge clk);
    w_en = 1'b0;
    rst_n = 1'b1;
    model_q.delete(); last_le = '0; last_be = '0;
    @(negedge clk);
    check("postrst level", 64'(a_lvl), 64'd0);

    // Symmetric instance: fill to full, then simultaneous read and write.
    for (int i = 0; i < 16; i++) begin
      n_w_en = 1'b1; n_w_data = 8'(8'hA0 + i);
      @(negedge clk);
    end
    n_w_en = 1'b0;
    check("narrow full level", 64'(n_lvl), 64'd16);
    check("narrow full flags", 64'({n_full, n_empty, n_af, n_ae}), 64'(4'b1010));
    n_w_en = 1'b1; n_w_data = 8'hEE; n_r_en = 1'b1;
    @(negedge clk);
    n_w_en = 1'b0; n_r_en = 1'b0;
    check("narrow rw level", 64'(n_lvl), 64'd15);
    check("narrow rw r_data", 64'(n_rdata), 64'hA0);
    check("narrow rw err", 64'({n_full, n_ovf, n_unf}), 64'(3'b010));
    n_r_en = 1'b1;
    @(negedge clk);
    n_r_en = 1'b0;
    check("narrow second read", 64'(n_rdata), 64'hA1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
